rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader: receives a length-prefixed image over a byte stream and writes
// it into the instruction ROM, holding the core off while loading.
// Stream format: 4-byte little-endian word count N, then N words of
// 4 little-endian bytes each.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start_i, core released
// S_LEN   | collecting the 4 word-count bytes
// S_DATA  | collecting the 4 bytes of the current word
// S_WRITE | one-cycle ROM write of the assembled word
// S_DONE  | one-cycle completion pulse
// S_ERR   | bad length or byte timeout, core held until next start_i
module rom_loader #(
    parameter int ROM_DEPTH      = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_ready_o,
    output logic        rom_wen_o,
    output logic [31:0] rom_waddr_o,
    output logic [31:0] rom_wdata_o,
    output logic        core_hold_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    // Word counters hold values up to ROM_DEPTH so they never wrap.
    localparam int CW = $clog2(ROM_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   DEPTH_W  = 32'(ROM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t         state;
    logic [1:0]     byte_cnt;
    logic [23:0]    shift_q;
    logic [CW-1:0]  n_words;
    logic [CW-1:0]  word_idx;
    logic [TW-1:0]  tmo_cnt;

    logic           accept;
    logic [31:0]    assembled;

    // The byte being accepted completes the little-endian word on top of the
    // three bytes already shifted in.
    assign accept    = rx_valid_i & rx_ready_o;
    assign assembled = {rx_data_i, shift_q};

    // Sequencer: state, counters and every output are registered together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            byte_cnt    <= 2'd0;
            shift_q     <= 24'd0;
            n_words     <= '0;
            word_idx    <= '0;
            tmo_cnt     <= '0;
            rx_ready_o  <= 1'b0;
            rom_wen_o   <= 1'b0;
            rom_waddr_o <= 32'd0;
            rom_wdata_o <= 32'd0;
            core_hold_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            rom_wen_o <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                S_IDLE, S_ERR: begin
                    if (start_i) begin
                        state       <= S_LEN;
                        err_o       <= 1'b0;
                        byte_cnt    <= 2'd0;
                        word_idx    <= '0;
                        tmo_cnt     <= '0;
                        rx_ready_o  <= 1'b1;
                        busy_o      <= 1'b1;
                        core_hold_o <= 1'b1;
                    end
                end
                S_LEN, S_DATA: begin
                    if (accept) begin
                        tmo_cnt  <= '0;
                        byte_cnt <= byte_cnt + 2'd1;
                        shift_q  <= {rx_data_i, shift_q[23:8]};
                        if (byte_cnt == 2'd3) begin
                            if (state == S_LEN) begin
                                if (assembled == 32'd0 || assembled > DEPTH_W) begin
                                    state      <= S_ERR;
                                    err_o      <= 1'b1;
                                    rx_ready_o <= 1'b0;
                                    busy_o     <= 1'b0;
                                end else begin
                                    n_words <= CW'(assembled);
                                    state   <= S_DATA;
                                end
                            end else begin
                                state       <= S_WRITE;
                                rx_ready_o  <= 1'b0;
                                rom_wen_o   <= 1'b1;
                                rom_waddr_o <= 32'({word_idx, 2'b00});
                                rom_wdata_o <= assembled;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state      <= S_ERR;
                        err_o      <= 1'b1;
                        rx_ready_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + CW'(1);
                    if (word_idx == n_words - CW'(1)) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        state      <= S_DATA;
                        rx_ready_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    core_hold_o <= 1'b0;
                end
                default: begin
                    state       <= S_IDLE;
                    rx_ready_o  <= 1'b0;
                    busy_o      <= 1'b0;
                    core_hold_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
